// File: rtl/npc_lsu_pkg.sv
// Shared types and helpers for the NPC load/store unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package npc_lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MREQ,
        ST_MWAIT,
        ST_RESP
    } lsu_state_e;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    // Natural alignment: the low 'size' address bits must all be zero.
    function automatic logic misaligned(input logic [2:0] ofs, input logic [1:0] size);
        logic m;
        case (size)
            SZ_B:    m = 1'b0;
            SZ_H:    m = ofs[0];
            SZ_W:    m = |ofs[1:0];
            default: m = |ofs;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/npc_lsu_if.sv
// Core-side and memory-side handshake bundles of the load/store unit.
// Latency: n/a (wires only).
// Backpressure: valid/ready on requests and core responses; memory responses are never stalled.
interface npc_lsu_req_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [XLEN-1:0]   req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [XLEN-1:0]   resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );
    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

interface npc_lsu_mem_if #(
    parameter int  XLEN   = 32,
    parameter int  ADDR_W = 32,
    localparam int NBYTES = XLEN / 8
);
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_req_we;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [XLEN-1:0]   mem_req_wdata;
    logic [NBYTES-1:0] mem_req_wstrb;
    logic              mem_resp_valid;
    logic [XLEN-1:0]   mem_resp_rdata;
    logic              mem_resp_err;

    modport master (
        output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wstrb,
        input  mem_req_ready, mem_resp_valid, mem_resp_rdata, mem_resp_err
    );
    modport slave (
        input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wstrb,
        output mem_req_ready, mem_resp_valid, mem_resp_rdata, mem_resp_err
    );
endinterface

// File: rtl/npc_lsu_align.sv
// Byte-lane steering: store strobes/data placement and load extraction with sign/zero extension.
// Latency: combinational.
// Backpressure: none.
module npc_lsu_align
    import npc_lsu_pkg::*;
#(
    parameter int  XLEN   = 32,
    localparam int NBYTES = XLEN / 8,
    localparam int OFS_W  = $clog2(NBYTES)
) (
    input  logic [OFS_W-1:0]  ofs,
    input  logic [1:0]        size,
    input  logic              is_unsigned,
    input  logic [XLEN-1:0]   st_data,
    input  logic [XLEN-1:0]   ld_beat,
    output logic [NBYTES-1:0] wstrb,
    output logic [XLEN-1:0]   wdata,
    output logic [XLEN-1:0]   rdata
);
    logic [NBYTES-1:0] lane_mask;
    logic [XLEN-1:0]   ld_shift;
    logic              sign;

    always_comb begin
        lane_mask = '0;
        for (int i = 0; i < NBYTES; i++) begin
            lane_mask[i] = (i < (1 << size));
        end
    end

    assign wstrb    = lane_mask << ofs;
    assign wdata    = st_data << {ofs, 3'b000};
    assign ld_shift = ld_beat >> {ofs, 3'b000};

    // A full-width access leaves every bit below 8<<size, so nothing is extended.
    always_comb begin
        case (size)
            SZ_B:    sign = ld_shift[7];
            SZ_H:    sign = ld_shift[15];
            default: sign = ld_shift[31];
        endcase
        sign  = sign & ~is_unsigned;
        rdata = ld_shift;
        for (int i = 0; i < XLEN; i++) begin
            if (i >= (8 << size)) rdata[i] = sign;
        end
    end

endmodule

// File: rtl/npc_lsu.sv
// Load/store unit: one core request -> at most one memory beat -> one extended response.
// Latency: 3 cycles accept-to-response with a zero-wait memory, 1 cycle for rejected accesses.
// Backpressure: req_ready only in IDLE; memory request and response held until their ready.
module npc_lsu
    import npc_lsu_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic          clk,
    input  logic          reset,
    npc_lsu_req_if.slave  core,
    npc_lsu_mem_if.master mem
);
    localparam int NBYTES = XLEN / 8;
    localparam int OFS_W  = $clog2(NBYTES);

    lsu_state_e        state, state_n;
    logic              r_we;
    logic              r_unsigned;
    logic              r_err;
    logic [1:0]        r_size;
    logic [ADDR_W-1:0] r_addr;
    logic [XLEN-1:0]   r_wdata;
    logic [XLEN-1:0]   r_rdata;

    logic [NBYTES-1:0] al_wstrb;
    logic [XLEN-1:0]   al_wdata;
    logic [XLEN-1:0]   al_rdata;
    logic              bad_req;

    assign bad_req = misaligned(core.req_addr[2:0], core.req_size)
                   || (core.req_size == SZ_D && XLEN < 64);

    npc_lsu_align #(.XLEN(XLEN)) u_align (
        .ofs         (r_addr[OFS_W-1:0]),
        .size        (r_size),
        .is_unsigned (r_unsigned),
        .st_data     (r_wdata),
        .ld_beat     (mem.mem_resp_rdata),
        .wstrb       (al_wstrb),
        .wdata       (al_wdata),
        .rdata       (al_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_n;
    end

    // Bus outputs are zero outside their own state so an idle LSU presents a quiet bus.
    always_comb begin
        state_n            = state;
        core.req_ready     = 1'b0;
        core.resp_valid    = 1'b0;
        core.resp_rdata    = '0;
        core.resp_err      = 1'b0;
        mem.mem_req_valid  = 1'b0;
        mem.mem_req_we     = 1'b0;
        mem.mem_req_addr   = '0;
        mem.mem_req_wdata  = '0;
        mem.mem_req_wstrb  = '0;
        case (state)
            ST_IDLE: begin
                core.req_ready = 1'b1;
                if (core.req_valid) state_n = bad_req ? ST_RESP : ST_MREQ;
            end
            ST_MREQ: begin
                mem.mem_req_valid = 1'b1;
                mem.mem_req_we    = r_we;
                mem.mem_req_addr  = {r_addr[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
                mem.mem_req_wdata = r_we ? al_wdata : '0;
                mem.mem_req_wstrb = r_we ? al_wstrb : '0;
                if (mem.mem_req_ready) state_n = ST_MWAIT;
            end
            ST_MWAIT: begin
                if (mem.mem_resp_valid) state_n = ST_RESP;
            end
            ST_RESP: begin
                core.resp_valid = 1'b1;
                core.resp_rdata = r_rdata;
                core.resp_err   = r_err;
                if (core.resp_ready) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_we       <= 1'b0;
            r_unsigned <= 1'b0;
            r_err      <= 1'b0;
            r_size     <= SZ_B;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
        end else if (state == ST_IDLE && core.req_valid) begin
            r_we       <= core.req_we;
            r_unsigned <= core.req_unsigned;
            r_size     <= core.req_size;
            r_addr     <= core.req_addr;
            r_wdata    <= core.req_wdata;
            r_err      <= bad_req;
            r_rdata    <= '0;
        end else if (state == ST_MWAIT && mem.mem_resp_valid) begin
            r_err      <= mem.mem_resp_err;
            r_rdata    <= (r_we || mem.mem_resp_err) ? '0 : al_rdata;
        end
    end

endmodule

// File: tb/tb_npc_lsu.sv
// Directed bench for npc_lsu at XLEN=32 and XLEN=64 with a scripted memory responder.
module tb_npc_lsu;
    import npc_lsu_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    npc_lsu_req_if #(.XLEN(32), .ADDR_W(32)) r32();
    npc_lsu_mem_if #(.XLEN(32), .ADDR_W(32)) m32();
    npc_lsu_req_if #(.XLEN(64), .ADDR_W(32)) r64();
    npc_lsu_mem_if #(.XLEN(64), .ADDR_W(32)) m64();

    npc_lsu #(.XLEN(32), .ADDR_W(32)) u_dut32 (.clk(clk), .reset(reset), .core(r32), .mem(m32));
    npc_lsu #(.XLEN(64), .ADDR_W(32)) u_dut64 (.clk(clk), .reset(reset), .core(r64), .mem(m64));

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // 32-bit memory model: ready held low for stall32 valid cycles, response lat32 cycles late
    int          stall32 = 0, lat32 = 0, cd32 = 0, hs_cnt32 = 0, vld_cyc32 = 0;
    logic [31:0] beat32 = '0;
    logic        berr32 = 1'b0;
    logic [31:0] hs_addr32, hs_wdata32;
    logic [3:0]  hs_wstrb32;
    logic        hs_we32, prev_vld32 = 1'b0, unstable32 = 1'b0;

    initial begin
        m32.mem_req_ready  = 1'b0;
        m32.mem_resp_valid = 1'b0;
        m32.mem_resp_rdata = '0;
        m32.mem_resp_err   = 1'b0;
        forever begin
            @(negedge clk);
            m32.mem_resp_valid = 1'b0;
            if (cd32 > 0) begin
                cd32--;
                if (cd32 == 0) begin
                    m32.mem_resp_valid = 1'b1;
                    m32.mem_resp_rdata = beat32;
                    m32.mem_resp_err   = berr32;
                end
            end
            if (m32.mem_req_valid) begin
                vld_cyc32++;
                if (prev_vld32 && (m32.mem_req_addr !== hs_addr32 || m32.mem_req_wdata !== hs_wdata32 ||
                                   m32.mem_req_wstrb !== hs_wstrb32 || m32.mem_req_we !== hs_we32))
                    unstable32 = 1'b1;
                hs_addr32  = m32.mem_req_addr;
                hs_wdata32 = m32.mem_req_wdata;
                hs_wstrb32 = m32.mem_req_wstrb;
                hs_we32    = m32.mem_req_we;
                if (stall32 > 0) begin
                    stall32--;
                    m32.mem_req_ready = 1'b0;
                end else begin
                    m32.mem_req_ready = 1'b1;
                    cd32 = lat32 + 1;
                    hs_cnt32++;
                end
            end else begin
                m32.mem_req_ready = 1'b0;
            end
            prev_vld32 = m32.mem_req_valid;
        end
    end

    // 64-bit memory model: always ready, responds the cycle after the handshake
    logic [63:0] beat64 = '0, hs_wdata64 = '0;
    logic [31:0] hs_addr64 = '0;
    logic [7:0]  hs_wstrb64 = '0;
    logic        pend64 = 1'b0;

    initial begin
        m64.mem_req_ready  = 1'b1;
        m64.mem_resp_valid = 1'b0;
        m64.mem_resp_rdata = '0;
        m64.mem_resp_err   = 1'b0;
        forever begin
            @(negedge clk);
            m64.mem_resp_valid = pend64;
            m64.mem_resp_rdata = beat64;
            pend64 = m64.mem_req_valid;
            if (m64.mem_req_valid) begin
                hs_addr64  = m64.mem_req_addr;
                hs_wdata64 = m64.mem_req_wdata;
                hs_wstrb64 = m64.mem_req_wstrb;
            end
        end
    end

    logic rr_seen, resp_unstable;

    // One full transaction; lat counts cycles from acceptance to the first visible resp_valid.
    task automatic tx(input bit w64, input logic we, input logic [1:0] size, input logic uns,
                      input logic [31:0] addr, input logic [63:0] wd, input int hold,
                      output logic [63:0] rd, output logic er, output int lat);
        logic rv, rr;
        @(negedge clk);
        if (w64) begin
            r64.req_valid = 1'b1; r64.req_we = we; r64.req_size = size;
            r64.req_unsigned = uns; r64.req_addr = addr; r64.req_wdata = wd;
        end else begin
            r32.req_valid = 1'b1; r32.req_we = we; r32.req_size = size;
            r32.req_unsigned = uns; r32.req_addr = addr; r32.req_wdata = wd[31:0];
        end
        rr_seen = 1'b0;
        resp_unstable = 1'b0;
        lat = 0;
        rd = '0;
        er = 1'b0;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            if (k == 1) begin
                r32.req_valid = 1'b0;
                r64.req_valid = 1'b0;
            end
            rv = w64 ? r64.resp_valid : r32.resp_valid;
            rr = w64 ? r64.req_ready : r32.req_ready;
            if (rv) begin
                lat = k;
                break;
            end
            if (rr) rr_seen = 1'b1;
        end
        if (lat == 0) begin
            chk("tx_timeout", 64'd0, 64'd1);
        end else begin
            rd = w64 ? r64.resp_rdata : {32'd0, r32.resp_rdata};
            er = w64 ? r64.resp_err : r32.resp_err;
            for (int k = 0; k < hold; k++) begin
                @(negedge clk);
                if (w64 ? (!r64.resp_valid || r64.resp_rdata !== rd || r64.resp_err !== er)
                        : (!r32.resp_valid || {32'd0, r32.resp_rdata} !== rd || r32.resp_err !== er))
                    resp_unstable = 1'b1;
                if (w64 ? r64.req_ready : r32.req_ready) rr_seen = 1'b1;
            end
            if (w64 ? r64.req_ready : r32.req_ready) rr_seen = 1'b1;
            if (w64) r64.resp_ready = 1'b1; else r32.resp_ready = 1'b1;
            @(negedge clk);
            r64.resp_ready = 1'b0;
            r32.resp_ready = 1'b0;
        end
    endtask

    logic [63:0] rd;
    logic        er;
    int          lat, hs_before;
    logic        stale_bad;

    initial begin
        r32.req_valid = 1'b0; r32.req_we = 1'b0; r32.req_size = SZ_B; r32.req_unsigned = 1'b0;
        r32.req_addr = '0; r32.req_wdata = '0; r32.resp_ready = 1'b0;
        r64.req_valid = 1'b0; r64.req_we = 1'b0; r64.req_size = SZ_B; r64.req_unsigned = 1'b0;
        r64.req_addr = '0; r64.req_wdata = '0; r64.resp_ready = 1'b0;
        reset = 1'b0;
        #1 reset = 1'b1;
        #2;
        chk("rst_req_ready", r32.req_ready, 1);
        chk("rst_resp_valid", r32.resp_valid, 0);
        chk("rst_resp_err", r32.resp_err, 0);
        chk("rst_resp_rdata", r32.resp_rdata, 0);
        chk("rst_mem_valid", m32.mem_req_valid, 0);
        chk("rst_mem_we", m32.mem_req_we, 0);
        chk("rst_mem_addr", m32.mem_req_addr, 0);
        chk("rst_mem_wdata", m32.mem_req_wdata, 0);
        chk("rst_mem_wstrb", m32.mem_req_wstrb, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // lw, zero-wait memory
        beat32 = 32'hDEADBEEF;
        tx(0, 1'b0, SZ_W, 1'b0, 32'h8000_0004, 64'd0, 0, rd, er, lat);
        chk("lw_addr", hs_addr32, 32'h8000_0004);
        chk("lw_wstrb", hs_wstrb32, 4'b0000);
        chk("lw_we", hs_we32, 0);
        chk("lw_rdata", rd, 64'hDEADBEEF);
        chk("lw_err", er, 0);
        chk("lw_latency", lat, 3);

        // lb / lbu from the top lane
        beat32 = 32'h80FF_0000;
        tx(0, 1'b0, SZ_B, 1'b0, 32'h8000_0003, 64'd0, 0, rd, er, lat);
        chk("lb_rdata", rd, 64'hFFFF_FF80);
        tx(0, 1'b0, SZ_B, 1'b1, 32'h8000_0003, 64'd0, 0, rd, er, lat);
        chk("lbu_rdata", rd, 64'h0000_0080);
        beat32 = 32'h0000_8001;
        tx(0, 1'b0, SZ_H, 1'b0, 32'h8000_0000, 64'd0, 0, rd, er, lat);
        chk("lh_rdata", rd, 64'hFFFF_8001);

        // sh to upper half
        beat32 = 32'h1234_5678;
        tx(0, 1'b1, SZ_H, 1'b0, 32'h8000_0002, 64'h0000_ABCD, 0, rd, er, lat);
        chk("sh_addr", hs_addr32, 32'h8000_0000);
        chk("sh_wstrb", hs_wstrb32, 4'b1100);
        chk("sh_wdata", hs_wdata32, 32'hABCD_0000);
        chk("sh_we", hs_we32, 1);
        chk("sh_err", er, 0);
        chk("sh_rdata", rd, 0);

        // misaligned and illegal size: no memory traffic, one-cycle error response
        hs_before = hs_cnt32;
        tx(0, 1'b0, SZ_W, 1'b0, 32'h8000_0002, 64'd0, 0, rd, er, lat);
        chk("mis_latency", lat, 1);
        chk("mis_err", er, 1);
        chk("mis_rdata", rd, 0);
        tx(0, 1'b0, SZ_D, 1'b0, 32'h8000_0000, 64'd0, 0, rd, er, lat);
        chk("sz3_latency", lat, 1);
        chk("sz3_err", er, 1);
        chk("no_mem_access", hs_cnt32, hs_before);

        // stalls everywhere plus bus error
        stall32 = 4; lat32 = 3; berr32 = 1'b1; beat32 = 32'h1234_5678;
        vld_cyc32 = 0; unstable32 = 1'b0;
        tx(0, 1'b0, SZ_H, 1'b0, 32'h8000_0006, 64'd0, 2, rd, er, lat);
        chk("stall_latency", lat, 10);
        chk("stall_vld_cycles", vld_cyc32, 5);
        chk("stall_mreq_stable", unstable32, 0);
        chk("stall_addr", hs_addr32, 32'h8000_0004);
        chk("stall_resp_stable", resp_unstable, 0);
        chk("stall_req_ready_low", rr_seen, 0);
        chk("berr_err", er, 1);
        chk("berr_rdata", rd, 0);
        chk("post_resp_valid", r32.resp_valid, 0);
        chk("post_req_ready", r32.req_ready, 1);
        berr32 = 1'b0;

        // reset while waiting for memory; the late response must be ignored
        lat32 = 3; beat32 = 32'hAAAA_5555;
        @(negedge clk);
        r32.req_valid = 1'b1; r32.req_we = 1'b0; r32.req_size = SZ_W;
        r32.req_unsigned = 1'b0; r32.req_addr = 32'h8000_0010;
        @(negedge clk);
        r32.req_valid = 1'b0;
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("arst_req_ready", r32.req_ready, 1);
        chk("arst_mem_valid", m32.mem_req_valid, 0);
        chk("arst_resp_valid", r32.resp_valid, 0);
        @(negedge clk);
        reset = 1'b0;
        stale_bad = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (r32.resp_valid || !r32.req_ready || m32.mem_req_valid) stale_bad = 1'b1;
        end
        chk("stale_ignored", stale_bad, 0);
        lat32 = 0; beat32 = 32'h1122_3344;
        tx(0, 1'b0, SZ_W, 1'b0, 32'h8000_0000, 64'd0, 0, rd, er, lat);
        chk("after_rst_rdata", rd, 64'h1122_3344);
        chk("after_rst_latency", lat, 3);

        // 64-bit instance
        beat64 = 64'h0123_4567_89AB_CDEF;
        tx(1, 1'b0, SZ_D, 1'b0, 32'h0000_0008, 64'd0, 0, rd, er, lat);
        chk("ld_rdata", rd, 64'h0123_4567_89AB_CDEF);
        chk("ld_addr", hs_addr64, 32'h0000_0008);
        chk("ld_latency", lat, 3);
        tx(1, 1'b0, SZ_W, 1'b0, 32'h0000_000C, 64'd0, 0, rd, er, lat);
        chk("lw64_hi_rdata", rd, 64'h0000_0000_0123_4567);
        chk("lw64_hi_addr", hs_addr64, 32'h0000_0008);
        tx(1, 1'b0, SZ_W, 1'b0, 32'h0000_0008, 64'd0, 0, rd, er, lat);
        chk("lw64_lo_rdata", rd, 64'hFFFF_FFFF_89AB_CDEF);
        tx(1, 1'b0, SZ_W, 1'b1, 32'h0000_0008, 64'd0, 0, rd, er, lat);
        chk("lwu64_rdata", rd, 64'h0000_0000_89AB_CDEF);
        tx(1, 1'b1, SZ_W, 1'b0, 32'h0000_000C, 64'h0000_0000_CAFE_F00D, 0, rd, er, lat);
        chk("sw64_wstrb", hs_wstrb64, 8'hF0);
        chk("sw64_wdata", hs_wdata64, 64'hCAFE_F00D_0000_0000);
        chk("sw64_err", er, 0);
        tx(1, 1'b0, SZ_D, 1'b0, 32'h0000_0004, 64'd0, 0, rd, er, lat);
        chk("ld64_mis_err", er, 1);
        chk("ld64_mis_latency", lat, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
